// File: rtl/rush_log_if.sv
// Lot-display bus for the rush-hour day logger: detector/hour inputs in,
// selected history entry and counters out.
interface rush_log_if #(
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic [3:0]  hour;
  logic [3:0]  rush_start;
  logic [3:0]  rush_end;
  logic        view_next;
  logic        view_valid;
  logic [AW-1:0] view_age;
  logic [3:0]  view_start;
  logic [3:0]  view_end;
  logic [AW:0] count;
  logic [3:0]  norush_days;

  modport master (
    output hour, rush_start, rush_end, view_next,
    input  view_valid, view_age, view_start, view_end, count, norush_days
  );

  modport slave (
    input  hour, rush_start, rush_end, view_next,
    output view_valid, view_age, view_start, view_end, count, norush_days
  );
endinterface

// File: rtl/rush_log.sv
// Day-history ring buffer of rush_start/rush_end pairs captured once per end of day.
// Optional no-rush day counter is built when RUSH_LOG_NORUSH_EN is defined.
module rush_log #(
  parameter int DEPTH = 4
) (
  input logic       clk,
  input logic       rst,
  rush_log_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   view_age_q, view_age_d;
  logic            view_valid_q, view_valid_d;
  logic [3:0]      view_start_q, view_start_d;
  logic [3:0]      view_end_q, view_end_d;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];
  logic            we;
  logic [AW-1:0]   rd_idx;

  always_comb begin
    state_d = state_q;
    we      = 1'b0;
    case (state_q)
      IDLE:   if (bus.hour == 4'd8) state_d = SETTLE;
      // detector outputs become valid one cycle after hour reaches 8
      SETTLE: begin
        state_d = HOLD;
        we      = 1'b1;
      end
      HOLD:   if (bus.hour != 4'd8) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[wr_ptr_q] = {bus.rush_start, bus.rush_end};

    wr_ptr_d = we ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d  = (we && count_q != CW'(DEPTH)) ? count_q + CW'(1) : count_q;

    view_age_d = view_age_q;
    if (we) begin
      view_age_d = '0;
    end else if (bus.view_next && count_q != '0) begin
      if (CW'(view_age_q) + CW'(1) == count_q) view_age_d = '0;
      else                                      view_age_d = view_age_q + AW'(1);
    end

    // look up from next-state values so a fresh write is shown immediately
    rd_idx       = wr_ptr_d - AW'(1) - view_age_d;
    view_start_d = mem_d[rd_idx][7:4];
    view_end_d   = mem_d[rd_idx][3:0];
    view_valid_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      view_age_q   <= '0;
      view_valid_q <= 1'b0;
      view_start_q <= 4'd0;
      view_end_q   <= 4'd0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'd0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      view_age_q   <= view_age_d;
      view_valid_q <= view_valid_d;
      view_start_q <= view_start_d;
      view_end_q   <= view_end_d;
      mem_q        <= mem_d;
    end
  end

  assign bus.view_valid = view_valid_q;
  assign bus.view_age   = view_age_q;
  assign bus.view_start = view_start_q;
  assign bus.view_end   = view_end_q;
  assign bus.count      = count_q;

`ifdef RUSH_LOG_NORUSH_EN
  logic [3:0] norush_q, norush_d;

  always_comb begin
    norush_d = norush_q;
    if (we && bus.rush_start == 4'd15 && norush_q != 4'd15) norush_d = norush_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) norush_q <= 4'd0;
    else     norush_q <= norush_d;
  end

  assign bus.norush_days = norush_q;
`else
  assign bus.norush_days = 4'd0;
`endif
endmodule

// File: tb/tb_rush_log.sv
// Directed bench for rush_log: capture timing, ring wrap, view stepping, reset.
module tb_rush_log;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rush_log_if #(.DEPTH(DEPTH)) bus ();

  rush_log #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive one end-of-day: hour=8 sampled at T, data valid T+1, back to 0 after write
  task automatic do_day(input logic [3:0] s, input logic [3:0] e);
    bus.hour = 4'd8;
    tick();
    bus.rush_start = s;
    bus.rush_end   = e;
    tick();
    bus.hour = 4'd0;
    tick();
  endtask

  task automatic pulse_view();
    bus.view_next = 1'b1;
    tick();
    bus.view_next = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.hour = 4'd0;
    bus.view_next = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (bus.count !== 3'd0 || bus.view_valid !== 1'b0 || bus.view_age !== 2'd0 ||
        bus.view_start !== 4'd0 || bus.view_end !== 4'd0 || bus.norush_days !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: count=%0d valid=%0b age=%0d start=%0d end=%0d norush=%0d, required all 0",
               bus.count, bus.view_valid, bus.view_age, bus.view_start, bus.view_end, bus.norush_days);
    end
    $display("reset: count=%0d valid=%0b", bus.count, bus.view_valid);
  endtask

  task automatic test_single_capture();
    apply_reset();
    bus.rush_start = 4'd14;
    bus.rush_end   = 4'd14;
    for (int h = 0; h < 8; h++) begin
      bus.hour = 4'(h);
      tick();
    end
    bus.hour = 4'd8;
    tick();
    checks++;
    if (bus.count !== 3'd0) begin
      errors++;
      $display("FAIL capture_not_early: count=%0d required 0", bus.count);
    end
    bus.rush_start = 4'd2;
    bus.rush_end   = 4'd4;
    tick();
    checks++;
    if (bus.count !== 3'd1 || bus.view_valid !== 1'b1 || bus.view_start !== 4'd2 ||
        bus.view_end !== 4'd4 || bus.view_age !== 2'd0) begin
      errors++;
      $display("FAIL capture_first: count=%0d valid=%0b start=%0d end=%0d age=%0d, required 1 1 2 4 0",
               bus.count, bus.view_valid, bus.view_start, bus.view_end, bus.view_age);
    end
    tick();
    checks++;
    if (bus.count !== 3'd1) begin
      errors++;
      $display("FAIL capture_once: count=%0d required 1", bus.count);
    end
    bus.hour = 4'd0;
    tick();
    $display("single capture: count=%0d start=%0d end=%0d", bus.count, bus.view_start, bus.view_end);
  endtask

  task automatic test_wrap_view();
    logic [3:0] exp_start [5];
    logic [1:0] exp_age   [5];
    exp_start = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd5};
    exp_age   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    apply_reset();
    for (int d = 1; d <= 5; d++) do_day(4'(d), 4'(d + 2));
    checks++;
    if (bus.count !== 3'd4) begin
      errors++;
      $display("FAIL wrap_count: count=%0d required 4", bus.count);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) pulse_view();
      checks++;
      if (bus.view_age !== exp_age[i] || bus.view_start !== exp_start[i] ||
          bus.view_end !== exp_start[i] + 4'd2) begin
        errors++;
        $display("FAIL wrap_view%0d: age=%0d start=%0d end=%0d, required %0d %0d %0d", i,
                 bus.view_age, bus.view_start, bus.view_end, exp_age[i], exp_start[i], exp_start[i] + 4'd2);
      end
      $display("view step %0d: age=%0d start=%0d end=%0d", i, bus.view_age, bus.view_start, bus.view_end);
    end
  endtask

  task automatic test_view_empty();
    apply_reset();
    pulse_view();
    checks++;
    if (bus.view_age !== 2'd0 || bus.view_valid !== 1'b0) begin
      errors++;
      $display("FAIL view_empty: age=%0d valid=%0b, required 0 0", bus.view_age, bus.view_valid);
    end
    do_day(4'd7, 4'd9);
    pulse_view();
    checks++;
    if (bus.view_age !== 2'd0 || bus.view_start !== 4'd7 || bus.view_end !== 4'd9) begin
      errors++;
      $display("FAIL view_one: age=%0d start=%0d end=%0d, required 0 7 9",
               bus.view_age, bus.view_start, bus.view_end);
    end
    $display("view empty/one: age=%0d valid=%0b", bus.view_age, bus.view_valid);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    do_day(4'd3, 4'd6);
    do_day(4'd15, 4'd15);
    pulse_view();
    checks++;
    if (bus.view_age !== 2'd1 || bus.view_start !== 4'd3 || bus.view_end !== 4'd6) begin
      errors++;
      $display("FAIL collide_setup: age=%0d start=%0d end=%0d, required 1 3 6",
               bus.view_age, bus.view_start, bus.view_end);
    end
    bus.hour = 4'd8;
    tick();
    bus.rush_start = 4'd10;
    bus.rush_end   = 4'd12;
    bus.view_next  = 1'b1;
    tick();
    bus.view_next = 1'b0;
    checks++;
    if (bus.view_age !== 2'd0 || bus.count !== 3'd3 || bus.view_start !== 4'd10 ||
        bus.view_end !== 4'd12) begin
      errors++;
      $display("FAIL collide_capture: age=%0d count=%0d start=%0d end=%0d, required 0 3 10 12",
               bus.view_age, bus.count, bus.view_start, bus.view_end);
    end
    bus.hour = 4'd0;
    tick();
    $display("capture vs view_next: age=%0d start=%0d", bus.view_age, bus.view_start);
  endtask

  task automatic test_reset_in_hold();
    apply_reset();
    do_day(4'd1, 4'd2);
    do_day(4'd3, 4'd4);
    bus.hour = 4'd8;
    tick();
    bus.rush_start = 4'd5;
    bus.rush_end   = 4'd6;
    tick();
    tick();
    checks++;
    if (bus.count !== 3'd3) begin
      errors++;
      $display("FAIL hold_setup: count=%0d required 3", bus.count);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.rush_start = 4'd9;
    bus.rush_end   = 4'd11;
    checks++;
    if (bus.count !== 3'd0 || bus.view_valid !== 1'b0 || bus.view_age !== 2'd0 ||
        bus.view_start !== 4'd0 || bus.view_end !== 4'd0 || bus.norush_days !== 4'd0) begin
      errors++;
      $display("FAIL hold_reset: count=%0d valid=%0b age=%0d start=%0d end=%0d norush=%0d, required all 0",
               bus.count, bus.view_valid, bus.view_age, bus.view_start, bus.view_end, bus.norush_days);
    end
    tick();
    checks++;
    if (bus.count !== 3'd0) begin
      errors++;
      $display("FAIL post_reset_settle: count=%0d required 0", bus.count);
    end
    tick();
    checks++;
    if (bus.count !== 3'd1 || bus.view_start !== 4'd9 || bus.view_end !== 4'd11) begin
      errors++;
      $display("FAIL post_reset_capture: count=%0d start=%0d end=%0d, required 1 9 11",
               bus.count, bus.view_start, bus.view_end);
    end
    bus.hour = 4'd0;
    tick();
    $display("reset in hold: count=%0d start=%0d", bus.count, bus.view_start);
  endtask

  task automatic test_norush();
    logic [3:0] exp_norush;
`ifdef RUSH_LOG_NORUSH_EN
    exp_norush = 4'd15;
`else
    exp_norush = 4'd0;
`endif
    apply_reset();
    for (int d = 0; d < 17; d++) do_day(4'd15, 4'd15);
    checks++;
    if (bus.norush_days !== exp_norush || bus.count !== 3'd4) begin
      errors++;
      $display("FAIL norush: norush=%0d count=%0d, required %0d 4", bus.norush_days, bus.count, exp_norush);
    end
    $display("norush after 17 days: %0d", bus.norush_days);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.hour = 4'd0;
    bus.rush_start = 4'd0;
    bus.rush_end = 4'd0;
    bus.view_next = 1'b0;
    test_reset();
    test_single_capture();
    test_wrap_view();
    test_view_empty();
    test_back_to_back();
    test_reset_in_hold();
    test_norush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rush_log.md
# rush_log

Day-history logger sitting directly downstream of the lot's rush-hour detector. At each end of the workday (hour 8) it captures the detector's `rush_start`/`rush_end` pair into a small ring buffer. It keeps the last `DEPTH` days and presents one selected entry for the lot display, stepped through by a one-cycle `view_next` pulse.

## Interface
Parameters:
- `DEPTH`, default 4: number of days kept; power of 2, range 2..16.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `hour`  in  4  current lot hour; 8 (4'b1000) = day over
- `rush_start`  in  4  detector's rush start hour (15 = no rush, 14 = unset)
- `rush_end`  in  4  detector's rush end hour (same encoding)
- `view_next`  in  1  single-cycle pulse; caller edge-detects keys
- `view_valid`  out  1  at least one day logged
- `view_age`  out  $clog2(DEPTH)  age of shown entry; 0 = newest
- `view_start`  out  4  stored start of shown entry
- `view_end`  out  4  stored end of shown entry
- `count`  out  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH
- `norush_days`  out  4  days logged with start = 15 (see Configuration)

## Operation
- Capture FSM states: IDLE, SETTLE, HOLD.
  - IDLE: `hour`==8 -> SETTLE; otherwise stay.
  - SETTLE: unconditional -> HOLD. On this cycle's edge, write {`rush_start`,`rush_end`} at `wr_ptr`.
  - HOLD: `hour`!=8 -> IDLE; otherwise stay.
- Capture rules:
  - Exactly one capture per contiguous run of `hour`==8.
  - Values are stored raw; no re-encoding of 14/15.
- Buffer:
  - `wr_ptr` increments modulo DEPTH on each write.
  - `count` increments on write and saturates at DEPTH.
  - When full, a write overwrites the oldest entry.
- Viewing:
  - `view_age` increments modulo `count` on `view_next`.
  - `view_next` has no effect while `count`==0.
  - The displayed entry index is (`wr_ptr` - 1 - `view_age`) mod DEPTH.
- Simultaneous capture and `view_next`: capture wins; `view_age` is forced to 0.
- Reset clears all of the following, and takes precedence on the same cycle as any event:
  - FSM -> IDLE, `wr_ptr` = 0, `count` = 0, `view_age` = 0
  - buffer contents = 0, `norush_days` = 0
  - `view_valid` = 0, `view_start` = 0, `view_end` = 0
- Reset mid-day or mid-HOLD discards history.
- If `hour`==8 is already present when reset releases, IDLE sees it and a capture occurs.

## Timing
- `hour` first sampled as 8 at edge T: FSM enters SETTLE.
  - The detector's registers update at this same edge, so inputs are valid during cycle T+1.
- Write occurs at edge T+1.
- `view_start`/`view_end`/`count`/`view_valid` show the new entry from cycle T+2. `view_age` = 0.
- `view_next` high at edge N: new `view_age` and entry data are visible after edge N. All outputs are registered.
- Minimum spacing between captures is 3 cycles: `hour` must leave 8 for at least one cycle.

## Configuration
- `RUSH_LOG_NORUSH_EN` defined:
  - `norush_days` increments on each capture whose `rush_start`==15.
  - It saturates at 15 and resets to 0.
- Not defined:
  - The counter logic is not built.
  - `norush_days` is tied to 0.

## Test plan
- Reset, then `hour` 0..7 then 8 held 3 cycles, with `rush_start`=2 and `rush_end`=4 from T+1:
  - exactly one write;
  - from T+2: `count`=1, `view_valid`=1, `view_start`=2, `view_end`=4, `view_age`=0.
- Five days with DEPTH=4, starts 1,2,3,4,5 (ends start+2):
  - `count`=4;
  - pulsing `view_next` 4 times gives starts 5,4,3,2,5 at ages 0,1,2,3,0.
- `view_next` with `count`=0:
  - `view_age` stays 0 and `view_valid` stays 0;
  - after one capture, `view_next` keeps `view_age` at 0 (modulo 1).
- `view_next` asserted in the SETTLE cycle with `count`=2 and `view_age`=1:
  - after the write, `view_age`=0 and the newest entry is shown.
- Assert `rst` during HOLD with `count`=3:
  - all outputs return to 0 next cycle;
  - `hour` still at 8 causes a fresh capture 2 cycles after reset release.
- With `RUSH_LOG_NORUSH_EN`, 17 days at start=15:
  - `norush_days`=15 (saturated).
- Without `RUSH_LOG_NORUSH_EN`, same stimulus:
  - `norush_days`=0.
